// File: rtl/mem_request_unit_if.sv
// Request/response channel between a pipeline stage and mem_request_unit.
// master = requesting stage, slave = the memory request unit.
interface mem_request_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_error;

  modport master (
    output req_valid, req_write, req_size, req_signed,
    output req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_error
  );

  modport slave (
    input  req_valid, req_write, req_size, req_signed,
    input  req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_error
  );
endinterface

// File: rtl/mem_request_unit.sv
// Single-outstanding load/store sequencer for the big-endian main memory.
// Drives the memory's rise-sample / fall-complete protocol.
module mem_request_unit #(
  parameter logic [31:0] OFFSET       = 32'h8002_0000,
  parameter int unsigned MEMORY_DEPTH = 1048576
) (
  input  logic                clk,
  input  logic                reset,
  mem_request_unit_if.slave   req_if,
  output logic [31:0]         mem_address,
  output logic [31:0]         mem_data_in,
  output logic [1:0]          mem_access_size,
  output logic                mem_write_enable,
  input  logic [31:0]         mem_data_out
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    RESP
  } state_t;

  localparam logic [32:0] LAST =
    {1'b0, OFFSET} + 33'(MEMORY_DEPTH) - 33'd1;

  state_t      state_q;
  state_t      state_d;
  logic        wr_q;
  logic [1:0]  size_q;
  logic        sgn_q;
  logic [2:0]  nbytes;
  logic [32:0] end_addr;
  logic        bad_size;
  logic        misal;
  logic        oor;
  logic        legal;
  logic [31:0] load_fmt;

  assign req_if.req_ready  = (state_q == IDLE);
  assign req_if.resp_valid = (state_q == RESP);

  // Access width and legality of the request currently offered.
  always_comb begin
    nbytes = 3'd0;
    unique case (1'b1)
      (req_if.req_size == 2'b01): nbytes = 3'd1;
      (req_if.req_size == 2'b10): nbytes = 3'd2;
      (req_if.req_size == 2'b11): nbytes = 3'd4;
      default:                    nbytes = 3'd0;
    endcase
    end_addr = {1'b0, req_if.req_addr} + 33'(nbytes) - 33'd1;
    bad_size = (req_if.req_size == 2'b00);
    misal    = ((req_if.req_size == 2'b11) &&
                (req_if.req_addr[1:0] != 2'b00)) ||
               ((req_if.req_size == 2'b10) &&
                req_if.req_addr[0]);
    oor      = (req_if.req_addr < OFFSET) ||
               (end_addr > LAST);
    legal    = !(bad_size || misal || oor);
  end

  // Load result extension; word loads and unsigned loads pass through.
  always_comb begin
    load_fmt = mem_data_out;
    unique case (1'b1)
      (sgn_q && size_q == 2'b01):
        load_fmt = {{24{mem_data_out[7]}}, mem_data_out[7:0]};
      (sgn_q && size_q == 2'b10):
        load_fmt = {{16{mem_data_out[15]}}, mem_data_out[15:0]};
      default:
        load_fmt = mem_data_out;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state: illegal requests bypass the memory entirely.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_if.req_valid)
                 state_d = legal ? ISSUE : RESP;
      ISSUE:   state_d = CAPTURE;
      CAPTURE: state_d = RESP;
      RESP:    if (req_if.resp_ready)
                 state_d = IDLE;
    endcase
  end

  // Registered memory drive and response data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q              <= 1'b0;
      size_q            <= 2'b00;
      sgn_q             <= 1'b0;
      mem_address       <= '0;
      mem_data_in       <= '0;
      mem_access_size   <= 2'b00;
      mem_write_enable  <= 1'b0;
      req_if.resp_rdata <= '0;
      req_if.resp_error <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_if.req_valid) begin
            wr_q              <= req_if.req_write;
            size_q            <= req_if.req_size;
            sgn_q             <= req_if.req_signed;
            req_if.resp_rdata <= '0;
            req_if.resp_error <= !legal;
            if (legal) begin
              mem_address      <= req_if.req_addr;
              mem_data_in      <= req_if.req_wdata;
              mem_access_size  <= req_if.req_size;
              mem_write_enable <= req_if.req_write;
            end
          end
        end
        CAPTURE: begin
          mem_address       <= '0;
          mem_data_in       <= '0;
          mem_access_size   <= 2'b00;
          mem_write_enable  <= 1'b0;
          req_if.resp_rdata <= wr_q ? 32'd0 : load_fmt;
        end
        RESP: begin
          if (req_if.resp_ready) begin
            req_if.resp_rdata <= '0;
            req_if.resp_error <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_request_unit.sv
// Bench for mem_request_unit: byte-array memory, spec-level model,
// table vectors, corner sequences and random traffic.
module tb_mem_request_unit;

  localparam logic [31:0] OFFSET = 32'h8002_0000;
  localparam int unsigned DEPTH  = 1048576;
  localparam longint      LASTA  = 64'h8011_FFFF;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_request_unit_if bus();
  logic [31:0] mem_address;
  logic [31:0] mem_data_in;
  logic [1:0]  mem_access_size;
  logic        mem_write_enable;
  logic [31:0] mem_data_out;

  mem_request_unit #(
    .OFFSET(OFFSET),
    .MEMORY_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_if(bus),
    .mem_address(mem_address),
    .mem_data_in(mem_data_in),
    .mem_access_size(mem_access_size),
    .mem_write_enable(mem_write_enable),
    .mem_data_out(mem_data_out)
  );

  int n_vec = 0;
  int n_err = 0;
  int we_cycles = 0;

  byte unsigned env_mem [DEPTH];
  byte unsigned ref_mem [DEPTH];

  function automatic int nbytes_of(input bit [1:0] s);
    case (s)
      2'b01:   return 1;
      2'b10:   return 2;
      2'b11:   return 4;
      default: return 0;
    endcase
  endfunction

  // Memory: registers inputs on the rising edge, acts on the falling edge.
  logic        m_we;
  logic [1:0]  m_sz;
  logic [31:0] m_a;
  logic [31:0] m_d;
  always @(posedge clk) begin
    m_we <= mem_write_enable;
    m_sz <= mem_access_size;
    m_a  <= mem_address;
    m_d  <= mem_data_in;
  end

  always @(negedge clk) begin
    int n;
    bit [31:0] v;
    n = nbytes_of(m_sz);
    if (n != 0 && m_a >= OFFSET &&
        longint'(m_a) + n - 1 <= LASTA) begin
      if (m_we) begin
        for (int i = 0; i < n; i++)
          env_mem[int'(m_a - OFFSET) + i] =
            8'(m_d >> (8 * (n - 1 - i)));
      end else begin
        v = 0;
        for (int i = 0; i < n; i++)
          v = (v << 8) | 32'(env_mem[int'(m_a - OFFSET) + i]);
        mem_data_out = v;
      end
    end else begin
      mem_data_out = 32'hA5A5_A5A5;
    end
  end

  always @(negedge clk)
    if (mem_write_enable === 1'b1) we_cycles++;

  function automatic void check(input string name,
                                input logic [31:0] got,
                                input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endfunction

  // Reference: legality and big-endian data from the rules alone.
  function automatic void model(input bit w, input bit [1:0] sz,
                                input bit sg, input bit [31:0] a,
                                input bit [31:0] wd,
                                output bit err,
                                output bit [31:0] rd);
    int n;
    longint v;
    n = nbytes_of(sz);
    err = 1'b0;
    rd = 32'd0;
    if (n == 0) err = 1'b1;
    else if ((a % 32'(n)) != 0) err = 1'b1;
    else if (a < OFFSET || longint'(a) + n - 1 > LASTA) err = 1'b1;
    if (err) return;
    if (w) begin
      for (int i = 0; i < n; i++)
        ref_mem[int'(a - OFFSET) + i] = 8'(wd >> (8 * (n - 1 - i)));
    end else begin
      v = 0;
      for (int i = 0; i < n; i++)
        v = v * 256 + longint'(ref_mem[int'(a - OFFSET) + i]);
      if (sg && n < 4 && v >= (longint'(1) << (8 * n - 1)))
        v = v - (longint'(1) << (8 * n));
      rd = 32'(v);
    end
  endfunction

  task automatic get_resp(input string tag, input bit exp_err,
                          input bit [31:0] exp_rd);
    int k;
    k = 0;
    while (bus.resp_valid !== 1'b1 && k < 8) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 8) begin
      n_vec++;
      n_err++;
      $display("FAIL %s resp_timeout: got none want resp", tag);
      return;
    end
    check({tag, " rdata"}, bus.resp_rdata, exp_rd);
    check({tag, " error"}, 32'(bus.resp_error), 32'(exp_err));
    check({tag, " mem_we_resp"}, 32'(mem_write_enable), 32'd0);
    check({tag, " mem_addr_resp"}, mem_address, 32'd0);
    @(negedge clk);
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    check({tag, " resp_drop"}, 32'(bus.resp_valid), 32'd0);
  endtask

  task automatic do_req(input string tag, input bit w,
                        input bit [1:0] sz, input bit sg,
                        input bit [31:0] a, input bit [31:0] wd,
                        input bit exp_err, input bit [31:0] exp_rd);
    int lat;
    int we0;
    @(negedge clk);
    check({tag, " ready"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_write  = w;
    bus.req_size   = sz;
    bus.req_signed = sg;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    bus.resp_ready = 1'b0;
    we0 = we_cycles;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;
    lat = 0;
    while (bus.resp_valid !== 1'b1 && lat < 8) begin
      if (!exp_err) begin
        check({tag, " mem_addr"}, mem_address, a);
        check({tag, " mem_din"}, mem_data_in, wd);
        check({tag, " mem_size"}, 32'(mem_access_size), 32'(sz));
        check({tag, " mem_we"}, 32'(mem_write_enable), 32'(w));
      end
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, 32'(lat + 1), exp_err ? 32'd1 : 32'd3);
    get_resp(tag, exp_err, exp_rd);
    if (exp_err)
      check({tag, " no_write"}, 32'(we_cycles - we0), 32'd0);
  endtask

  typedef struct {
    bit        w;
    bit [1:0]  sz;
    bit        sg;
    bit [31:0] a;
    bit [31:0] wd;
    bit        err;
    bit [31:0] rd;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input bit w, input bit [1:0] sz,
                              input bit sg, input bit [31:0] a,
                              input bit [31:0] wd, input bit err,
                              input bit [31:0] rd);
    vec_t v;
    v.w = w; v.sz = sz; v.sg = sg; v.a = a;
    v.wd = wd; v.err = err; v.rd = rd;
    tbl.push_back(v);
  endfunction

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin : main
    bit        e;
    bit [31:0] r;
    bit [31:0] bw_a  [4];
    bit [31:0] bw_d  [4];
    bit        bw_w  [4];
    bit [1:0]  bw_sz [4];
    bit        bw_e  [4];
    bit [31:0] bw_r  [4];
    int idx, got, last_acc;
    bit rdy, rv;

    reset = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_size = 2'b00;
    bus.req_signed = 1'b0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    bus.resp_ready = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("rst req_ready", 32'(bus.req_ready), 32'd1);
    check("rst resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst resp_rdata", bus.resp_rdata, 32'd0);
    check("rst resp_error", 32'(bus.resp_error), 32'd0);
    check("rst mem_addr", mem_address, 32'd0);
    check("rst mem_we", 32'(mem_write_enable), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;

    add(1, 2'b11, 0, 32'h8002_0000, 32'hDEAD_BEEF, 0, 32'h0);
    add(0, 2'b11, 0, 32'h8002_0000, 32'h0, 0, 32'hDEAD_BEEF);
    add(0, 2'b01, 1, 32'h8002_0000, 32'h0, 0, 32'hFFFF_FFDE);
    add(0, 2'b01, 0, 32'h8002_0000, 32'h0, 0, 32'h0000_00DE);
    add(0, 2'b10, 1, 32'h8002_0002, 32'h0, 0, 32'hFFFF_BEEF);
    add(0, 2'b10, 0, 32'h8002_0002, 32'h0, 0, 32'h0000_BEEF);
    add(0, 2'b10, 1, 32'h8002_0000, 32'h0, 0, 32'hFFFF_DEAD);
    add(0, 2'b11, 1, 32'h8002_0000, 32'h0, 0, 32'hDEAD_BEEF);
    add(0, 2'b11, 0, 32'h8002_0002, 32'h0, 1, 32'h0);
    add(1, 2'b11, 0, 32'h8012_0000, 32'h1234_5678, 1, 32'h0);
    add(0, 2'b11, 0, 32'h8002_0000, 32'h0, 0, 32'hDEAD_BEEF);
    add(1, 2'b01, 0, 32'h8011_FFFF, 32'hFFFF_FF7F, 0, 32'h0);
    add(0, 2'b01, 1, 32'h8011_FFFF, 32'h0, 0, 32'h0000_007F);
    add(1, 2'b10, 0, 32'h8011_FFFE, 32'hAAAA_80A1, 0, 32'h0);
    add(0, 2'b10, 1, 32'h8011_FFFE, 32'h0, 0, 32'hFFFF_80A1);
    add(0, 2'b01, 0, 32'h8011_FFFF, 32'h0, 0, 32'h0000_00A1);
    add(0, 2'b01, 1, 32'h8011_FFFF, 32'h0, 0, 32'hFFFF_FFA1);
    add(1, 2'b11, 0, 32'h8011_FFFC, 32'hCAFE_F00D, 0, 32'h0);
    add(0, 2'b11, 0, 32'h8011_FFFC, 32'h0, 0, 32'hCAFE_F00D);
    add(0, 2'b10, 0, 32'h8011_FFFE, 32'h0, 0, 32'h0000_F00D);
    add(0, 2'b10, 0, 32'h8011_FFFF, 32'h0, 1, 32'h0);
    add(1, 2'b10, 0, 32'h8002_0001, 32'h1, 1, 32'h0);
    add(0, 2'b01, 0, 32'h8001_FFFF, 32'h0, 1, 32'h0);
    add(1, 2'b01, 0, 32'h8012_0000, 32'h5A, 1, 32'h0);
    add(1, 2'b00, 0, 32'h8002_0000, 32'h0, 1, 32'h0);
    add(0, 2'b11, 0, 32'h0000_0000, 32'h0, 1, 32'h0);

    for (int i = 0; i < tbl.size(); i++) begin
      model(tbl[i].w, tbl[i].sz, tbl[i].sg, tbl[i].a, tbl[i].wd, e, r);
      do_req($sformatf("vec%0d", i), tbl[i].w, tbl[i].sz, tbl[i].sg,
             tbl[i].a, tbl[i].wd, tbl[i].err, tbl[i].rd);
    end

    // Backpressure: response held, a pending request must wait.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_size = 2'b11;
    bus.req_signed = 1'b0;
    bus.req_addr = 32'h8002_0000;
    @(posedge clk); #1;
    bus.req_write = 1'b1;
    bus.req_addr = 32'h8002_0010;
    bus.req_wdata = 32'h5566_7788;
    repeat (2) @(posedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp resp_valid", 32'(bus.resp_valid), 32'd1);
      check("bp rdata", bus.resp_rdata, 32'hDEAD_BEEF);
      check("bp req_ready", 32'(bus.req_ready), 32'd0);
    end
    @(negedge clk) bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    check("bp idle_ready", 32'(bus.req_ready), 32'd1);
    check("bp resp_drop", 32'(bus.resp_valid), 32'd0);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check("bp accepted", 32'(bus.req_ready), 32'd0);
    check("bp mem_addr", mem_address, 32'h8002_0010);
    check("bp mem_we", 32'(mem_write_enable), 32'd1);
    model(1, 2'b11, 0, 32'h8002_0010, 32'h5566_7788, e, r);
    get_resp("bp store", 1'b0, 32'h0);

    // Reset while a store is in ISSUE: store is lost, no response.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_size = 2'b11;
    bus.req_addr = 32'h8002_0000;
    bus.req_wdata = 32'h1122_3344;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check("rs issue_we", 32'(mem_write_enable), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("rs req_ready", 32'(bus.req_ready), 32'd1);
    check("rs resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rs mem_we", 32'(mem_write_enable), 32'd0);
    check("rs mem_addr", mem_address, 32'd0);
    check("rs mem_din", mem_data_in, 32'd0);
    check("rs mem_size", 32'(mem_access_size), 32'd0);
    check("rs rdata", bus.resp_rdata, 32'd0);
    check("rs error", 32'(bus.resp_error), 32'd0);
    @(posedge clk);
    @(negedge clk) reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("rs no_resp", 32'(bus.resp_valid), 32'd0);
    end
    do_req("rs readback", 0, 2'b11, 0, 32'h8002_0000, 32'h0,
           1'b0, 32'hDEAD_BEEF);

    // Back-to-back alternating store/load with req_valid held.
    bw_w[0] = 1; bw_sz[0] = 2'b11; bw_a[0] = 32'h8002_0100;
    bw_d[0] = 32'hA1B2_C3D4;
    bw_w[1] = 0; bw_sz[1] = 2'b11; bw_a[1] = 32'h8002_0100;
    bw_d[1] = 32'h0;
    bw_w[2] = 1; bw_sz[2] = 2'b10; bw_a[2] = 32'h8002_0102;
    bw_d[2] = 32'h0000_FEDC;
    bw_w[3] = 0; bw_sz[3] = 2'b11; bw_a[3] = 32'h8002_0100;
    bw_d[3] = 32'h0;
    for (int i = 0; i < 4; i++)
      model(bw_w[i], bw_sz[i], 1'b0, bw_a[i], bw_d[i], bw_e[i], bw_r[i]);
    check("b2b model", bw_r[3], 32'hA1B2_FEDC);
    idx = 0;
    got = 0;
    last_acc = 0;
    bus.resp_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      @(negedge clk);
      bus.req_valid = (idx < 4);
      if (idx < 4) begin
        bus.req_write = bw_w[idx];
        bus.req_size = bw_sz[idx];
        bus.req_signed = 1'b0;
        bus.req_addr = bw_a[idx];
        bus.req_wdata = bw_d[idx];
      end
      rdy = bus.req_ready;
      rv = bus.resp_valid;
      if (rv) begin
        check($sformatf("b2b rdata%0d", got), bus.resp_rdata, bw_r[got]);
        check($sformatf("b2b err%0d", got), 32'(bus.resp_error),
              32'(bw_e[got]));
        got++;
      end
      @(posedge clk);
      if (rdy && bus.req_valid) begin
        if (idx > 0)
          check("b2b spacing", 32'(cyc - last_acc), 32'd4);
        last_acc = cyc;
        idx++;
      end
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.resp_ready = 1'b0;
    check("b2b responses", 32'(got), 32'd4);

    // Random traffic against the reference model.
    for (int i = 0; i < 80; i++) begin
      bit        w, sg;
      bit [1:0]  sz;
      bit [31:0] a, wd;
      w  = 1'($urandom_range(0, 1));
      sg = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      wd = $urandom;
      case ($urandom_range(0, 3))
        0: a = OFFSET + 32'($urandom_range(0, 31));
        1: a = 32'(LASTA) - 32'($urandom_range(0, 7));
        2: a = OFFSET - 32'($urandom_range(1, 4));
        default: a = 32'(LASTA) + 32'($urandom_range(1, 4));
      endcase
      model(w, sz, sg, a, wd, e, r);
      do_req($sformatf("rnd%0d", i), w, sz, sg, a, wd, e, r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
